// File: rtl/mac_operand_loader_if.sv
// -----------------------------------------------------------------------------
// mac_operand_loader_if
//
// Bundles every stream signal between the operand loader and its neighbours:
// the activation input stream, the weight input stream, and the vector
// output stream toward the MAC array.
//
// Handshake rule for all three streams: a transfer happens on a rising clk
// edge where valid and ready are both 1. A source that raises valid must hold
// valid and data until that edge. ready may be 0 while valid is 1, and ready
// never depends combinationally on valid.
//
// Parameters
//   N     elements per vector
//   BEAT  elements per input beat
//
// Signals
//   act_valid/act_ready/act_data  activation beats, 4-bit elements, el 0 in [3:0]
//   wgt_valid/wgt_ready/wgt_data  weight beats, 8-bit elements, el 0 in [7:0]
//   wgt_keep                      sampled at output handshake; 1 keeps weights
//   out_valid/out_ready           vector handshake toward the MAC
//   din/weight                    assembled activation / weight vectors
//   act_state/wgt_state           debug view of each fill engine
//                                 (0 = empty, 1 = filling, 2 = full)
//
// Modports
//   slave   the loader itself
//   master  the environment (sources plus MAC sink)
// -----------------------------------------------------------------------------
interface mac_operand_loader_if #(
  parameter int N    = 1152,
  parameter int BEAT = 8
);
  logic              act_valid;
  logic              act_ready;
  logic [4*BEAT-1:0] act_data;
  logic              wgt_valid;
  logic              wgt_ready;
  logic [8*BEAT-1:0] wgt_data;
  logic              wgt_keep;
  logic              out_valid;
  logic              out_ready;
  logic [4*N-1:0]    din;
  logic [8*N-1:0]    weight;
  logic [1:0]        act_state;
  logic [1:0]        wgt_state;

  modport slave (
    input  act_valid, act_data,
    input  wgt_valid, wgt_data, wgt_keep,
    input  out_ready,
    output act_ready, wgt_ready,
    output out_valid, din, weight,
    output act_state, wgt_state
  );

  modport master (
    output act_valid, act_data,
    output wgt_valid, wgt_data, wgt_keep,
    output out_ready,
    input  act_ready, wgt_ready,
    input  out_valid, din, weight,
    input  act_state, wgt_state
  );
endinterface

// File: rtl/mac_operand_loader.sv
// -----------------------------------------------------------------------------
// mac_operand_loader
//
// Staging buffer in front of mac_new. Two independent fill engines collect
// narrow activation beats and weight beats into full N-element vectors. When
// both vectors are complete they are offered to the MAC over a valid/ready
// handshake. The weight vector can be retained across several activation
// vectors by holding wgt_keep high at the handshake.
//
// Data are copied bit-exact; no arithmetic is done here.
//
// Ports
//   clk  sole clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  mac_operand_loader_if.slave (stream inputs, vector outputs, debug)
// -----------------------------------------------------------------------------
module mac_operand_loader #(
  parameter int N    = 1152,
  parameter int BEAT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_operand_loader_if.slave   bus
);

  localparam int NB    = N / BEAT;
  // Width of the beat counter; kept at least 1 so a single-beat vector
  // still gets a legal register.
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW    = 4 * BEAT;
  localparam int WW    = 8 * BEAT;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);

  // Elaboration-time guard: the vector must be a whole number of beats.
  if ((BEAT <= 0) || (N % BEAT != 0)) begin : g_bad_param
    $error("mac_operand_loader: N (%0d) must be a positive multiple of BEAT (%0d)",
           N, BEAT);
  end

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } fill_state_e;

  fill_state_e      act_state_q, act_state_d;
  fill_state_e      wgt_state_q, wgt_state_d;
  logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
  logic [CNT_W-1:0] wgt_cnt_q, wgt_cnt_d;
  logic [4*N-1:0]   din_q;
  logic [8*N-1:0]   weight_q;

  logic act_full;
  logic wgt_full;
  logic act_acc;
  logic wgt_acc;
  logic out_hs;

  // ---------------------------------------------------------------------------
  // Handshake decode. Everything here depends on registered state only for
  // the readies and out_valid; inputs enter only the accept/handshake terms.
  // ---------------------------------------------------------------------------
  assign act_full = (act_state_q == ST_FULL);
  assign wgt_full = (wgt_state_q == ST_FULL);

  assign bus.act_ready = !act_full;
  assign bus.wgt_ready = !wgt_full;
  assign bus.out_valid = act_full & wgt_full;

  assign act_acc = bus.act_valid & !act_full;
  assign wgt_acc = bus.wgt_valid & !wgt_full;
  assign out_hs  = act_full & wgt_full & bus.out_ready;

  assign bus.din       = din_q;
  assign bus.weight    = weight_q;
  assign bus.act_state = act_state_q;
  assign bus.wgt_state = wgt_state_q;

  // ---------------------------------------------------------------------------
  // Activation fill engine: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    act_state_d = act_state_q;
    act_cnt_d   = act_cnt_q;
    case (act_state_q)
      ST_EMPTY, ST_FILLING: begin
        if (act_acc) begin
          if (act_cnt_q == LAST_BEAT) begin
            act_cnt_d   = '0;
            act_state_d = ST_FULL;
          end else begin
            act_cnt_d   = act_cnt_q + CNT_W'(1);
            act_state_d = ST_FILLING;
          end
        end
      end
      ST_FULL: begin
        // The activation vector is always consumed by a handshake; the
        // first beat of the next vector is only accepted a cycle later
        // because the ready is still low in the handshake cycle.
        if (out_hs) begin
          act_state_d = ST_EMPTY;
        end
      end
      default: begin
        act_state_d = ST_EMPTY;
        act_cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Weight fill engine: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wgt_state_d = wgt_state_q;
    wgt_cnt_d   = wgt_cnt_q;
    case (wgt_state_q)
      ST_EMPTY, ST_FILLING: begin
        if (wgt_acc) begin
          if (wgt_cnt_q == LAST_BEAT) begin
            wgt_cnt_d   = '0;
            wgt_state_d = ST_FULL;
          end else begin
            wgt_cnt_d   = wgt_cnt_q + CNT_W'(1);
            wgt_state_d = ST_FILLING;
          end
        end
      end
      ST_FULL: begin
        // wgt_keep = 1 retains the vector for the next activation vector,
        // leaving the weight stream stalled.
        if (out_hs && !bus.wgt_keep) begin
          wgt_state_d = ST_EMPTY;
        end
      end
      default: begin
        wgt_state_d = ST_EMPTY;
        wgt_cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_state_q <= ST_EMPTY;
      wgt_state_q <= ST_EMPTY;
      act_cnt_q   <= '0;
      wgt_cnt_q   <= '0;
    end else begin
      act_state_q <= act_state_d;
      wgt_state_q <= wgt_state_d;
      act_cnt_q   <= act_cnt_d;
      wgt_cnt_q   <= wgt_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector storage. Each accepted beat lands in the slot selected by the
  // beat counter. Nothing is cleared on handshake: stale data stays until
  // overwritten, and the MAC qualifies with out_valid. While out_valid is
  // high both readies are low, so neither vector can change.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q <= '0;
    end else if (act_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (act_cnt_q == CNT_W'(b)) begin
          din_q[b*AW +: AW] <= bus.act_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_q <= '0;
    end else if (wgt_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (wgt_cnt_q == CNT_W'(b)) begin
          weight_q[b*WW +: WW] <= bus.wgt_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_loader.sv
module tb_mac_operand_loader;

  // Small instance for directed scenarios, default-sized instance for the
  // randomized scoreboard run.
  localparam int SN   = 16;
  localparam int SB   = 4;
  localparam int SNB  = SN / SB;
  localparam int SAW  = 4 * SB;
  localparam int SWW  = 8 * SB;
  localparam int BN   = 1152;
  localparam int BB   = 8;
  localparam int BNB  = BN / BB;
  localparam int BAW  = 4 * BB;
  localparam int BWW  = 8 * BB;
  localparam int NVEC = 50;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_operand_loader_if #(.N(SN), .BEAT(SB)) sif ();
  mac_operand_loader_if #(.N(BN), .BEAT(BB)) bif ();

  mac_operand_loader #(.N(SN), .BEAT(SB)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  mac_operand_loader #(.N(BN), .BEAT(BB)) u_big (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Small-instance stimulus and expected vectors
  logic [SAW-1:0]  a_beats [SNB];
  logic [SWW-1:0]  w_beats [SNB];
  logic [4*SN-1:0] exp_din;
  logic [8*SN-1:0] exp_wgt;

  // Scoreboard for the default-sized instance
  logic [4*BN-1:0] cur_act;
  logic [8*BN-1:0] cur_wgt;
  logic [4*BN-1:0] exp_act_q[$];
  logic [8*BN-1:0] exp_wgt_q[$];

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fresh random beats; the expected vector is simply the beats laid side by
  // side, beat k at element offset k*BEAT. Beats are forced nonzero so that
  // a reset to zero is always visible.
  task automatic gen_small(input bit new_act, input bit new_wgt);
    for (int i = 0; i < SNB; i++) begin
      if (new_act) begin
        a_beats[i] = SAW'($urandom) | SAW'(1);
        exp_din[i*SAW +: SAW] = a_beats[i];
      end
      if (new_wgt) begin
        w_beats[i] = SWW'($urandom) | SWW'(1);
        exp_wgt[i*SWW +: SWW] = w_beats[i];
      end
    end
  endtask

  task automatic idle_small();
    sif.act_valid = 1'b0;
    sif.wgt_valid = 1'b0;
    sif.act_data  = '0;
    sif.wgt_data  = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle_small();
    sif.out_ready = 1'b0;
    sif.wgt_keep  = 1'b0;
    bif.act_valid = 1'b0;
    bif.wgt_valid = 1'b0;
    bif.act_data  = '0;
    bif.wgt_data  = '0;
    bif.out_ready = 1'b0;
    bif.wgt_keep  = 1'b0;
    #1;
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", sif.out_valid); end
    checks++; if (sif.act_ready !== 1'b1 || sif.wgt_ready !== 1'b1) begin errors++; $display("FAIL reset_readies got %b%b exp 11", sif.act_ready, sif.wgt_ready); end
    checks++; if (sif.din !== '0 || sif.weight !== '0) begin errors++; $display("FAIL reset_vectors din %h weight %h exp 0", sif.din, sif.weight); end
    checks++; if (bif.out_valid !== 1'b0 || bif.act_ready !== 1'b1 || bif.wgt_ready !== 1'b1) begin errors++; $display("FAIL reset_big_flags got v%b a%b w%b exp v0 a1 w1", bif.out_valid, bif.act_ready, bif.wgt_ready); end
    checks++; if (bif.din !== '0 || bif.weight !== '0) begin errors++; $display("FAIL reset_big_vectors not zero"); end
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (sif.out_valid !== 1'b0 || sif.act_ready !== 1'b1 || sif.wgt_ready !== 1'b1) begin errors++; $display("FAIL post_reset_flags got v%b a%b w%b exp v0 a1 w1", sif.out_valid, sif.act_ready, sif.wgt_ready); end
  endtask

  task automatic test_basic();
    logic [SAW-1:0] ab [SNB];
    logic [SWW-1:0] wb [SNB];
    ab[0] = 16'h4321; ab[1] = 16'h8765; ab[2] = 16'hCBA9; ab[3] = 16'h0FED;
    wb[0] = 32'h04030201; wb[1] = 32'h08070605; wb[2] = 32'h0C0B0A09; wb[3] = 32'h100F0E0D;
    sif.out_ready = 1'b1;
    sif.wgt_keep  = 1'b0;
    for (int i = 0; i < SNB; i++) begin
      sif.act_valid = 1'b1; sif.act_data = ab[i];
      sif.wgt_valid = 1'b1; sif.wgt_data = wb[i];
      step();
      if (i < SNB - 1) begin
        checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid beat %0d got %b exp 0", i, sif.out_valid); end
      end
    end
    idle_small();
    checks++; if (sif.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", sif.out_valid); end
    checks++; if (sif.din !== 64'h0FEDCBA987654321) begin errors++; $display("FAIL basic_din got %h exp 0fedcba987654321", sif.din); end
    checks++; if (sif.weight !== 128'h100F0E0D0C0B0A090807060504030201) begin errors++; $display("FAIL basic_weight got %h exp 100f0e0d0c0b0a090807060504030201", sif.weight); end
    checks++; if (sif.act_ready !== 1'b0 || sif.wgt_ready !== 1'b0) begin errors++; $display("FAIL basic_readies_full got %b%b exp 00", sif.act_ready, sif.wgt_ready); end
    step();
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_cycle got %b exp 0", sif.out_valid); end
    checks++; if (sif.act_ready !== 1'b1 || sif.wgt_ready !== 1'b1) begin errors++; $display("FAIL basic_readies_after got %b%b exp 11", sif.act_ready, sif.wgt_ready); end
  endtask

  task automatic test_skew();
    int bad_ready = 0;
    gen_small(1'b1, 1'b1);
    sif.out_ready = 1'b1;
    sif.wgt_keep  = 1'b0;
    for (int i = 0; i < SNB; i++) begin
      sif.act_valid = 1'b1; sif.act_data = a_beats[i];
      step();
    end
    idle_small();
    for (int d = 0; d < 20; d++) begin
      // Stale input offered while full must be ignored.
      sif.act_valid = 1'b1; sif.act_data = ~a_beats[d % SNB];
      if (sif.act_ready !== 1'b0 || sif.out_valid !== 1'b0) bad_ready++;
      step();
    end
    sif.act_valid = 1'b0;
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL skew_act_stall cycles_wrong %0d exp 0", bad_ready); end
    for (int i = 0; i < SNB; i++) begin
      sif.wgt_valid = 1'b1; sif.wgt_data = w_beats[i];
      step();
      if (i < SNB - 1) begin
        checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL skew_early_valid beat %0d got %b exp 0", i, sif.out_valid); end
      end
    end
    idle_small();
    checks++; if (sif.out_valid !== 1'b1) begin errors++; $display("FAIL skew_out_valid got %b exp 1", sif.out_valid); end
    checks++; if (sif.din !== exp_din) begin errors++; $display("FAIL skew_din got %h exp %h", sif.din, exp_din); end
    checks++; if (sif.weight !== exp_wgt) begin errors++; $display("FAIL skew_weight got %h exp %h", sif.weight, exp_wgt); end
    step();
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL skew_hs got %b exp 0", sif.out_valid); end
  endtask

  task automatic test_backpressure();
    gen_small(1'b1, 1'b1);
    sif.out_ready = 1'b0;
    sif.wgt_keep  = 1'b0;
    for (int i = 0; i < SNB; i++) begin
      sif.act_valid = 1'b1; sif.act_data = a_beats[i];
      sif.wgt_valid = 1'b1; sif.wgt_data = w_beats[i];
      step();
    end
    checks++; if (sif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b exp 1", sif.out_valid); end
    for (int c = 0; c < 10; c++) begin
      sif.act_valid = 1'b1; sif.act_data = ~a_beats[0];
      sif.wgt_valid = 1'b1; sif.wgt_data = ~w_beats[0];
      step();
      checks++; if (sif.din !== exp_din || sif.weight !== exp_wgt) begin errors++; $display("FAIL bp_hold cycle %0d din %h weight %h exp %h %h", c, sif.din, sif.weight, exp_din, exp_wgt); end
      checks++; if (sif.act_ready !== 1'b0 || sif.wgt_ready !== 1'b0 || sif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_flags cycle %0d got a%b w%b v%b exp a0 w0 v1", c, sif.act_ready, sif.wgt_ready, sif.out_valid); end
    end
    idle_small();
    sif.out_ready = 1'b1;
    step();
    checks++; if (sif.out_valid !== 1'b0 || sif.act_ready !== 1'b1 || sif.wgt_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v%b a%b w%b exp v0 a1 w1", sif.out_valid, sif.act_ready, sif.wgt_ready); end
    checks++; if (sif.din !== exp_din || sif.weight !== exp_wgt) begin errors++; $display("FAIL bp_not_cleared din %h weight %h exp %h %h", sif.din, sif.weight, exp_din, exp_wgt); end
  endtask

  task automatic test_weight_reuse();
    logic [8*SN-1:0] kept_wgt;
    int bad_ready = 0;
    gen_small(1'b1, 1'b1);
    kept_wgt      = exp_wgt;
    sif.out_ready = 1'b1;
    sif.wgt_keep  = 1'b1;
    for (int i = 0; i < SNB; i++) begin
      sif.act_valid = 1'b1; sif.act_data = a_beats[i];
      sif.wgt_valid = 1'b1; sif.wgt_data = w_beats[i];
      step();
    end
    idle_small();
    checks++; if (sif.out_valid !== 1'b1 || sif.din !== exp_din || sif.weight !== kept_wgt) begin errors++; $display("FAIL reuse_first v%b din %h weight %h exp v1 %h %h", sif.out_valid, sif.din, sif.weight, exp_din, kept_wgt); end
    step();
    checks++; if (sif.act_ready !== 1'b1 || sif.wgt_ready !== 1'b0 || sif.out_valid !== 1'b0) begin errors++; $display("FAIL reuse_after_hs got a%b w%b v%b exp a1 w0 v0", sif.act_ready, sif.wgt_ready, sif.out_valid); end
    gen_small(1'b1, 1'b0);
    for (int i = 0; i < SNB; i++) begin
      sif.act_valid = 1'b1; sif.act_data = a_beats[i];
      sif.wgt_valid = 1'b1; sif.wgt_data = ~kept_wgt[SWW-1:0];
      if (sif.wgt_ready !== 1'b0) bad_ready++;
      step();
    end
    idle_small();
    sif.wgt_keep = 1'b0;
    checks++; if (bad_ready != 0 || sif.wgt_ready !== 1'b0) begin errors++; $display("FAIL reuse_wgt_stall cycles_wrong %0d ready %b exp 0 0", bad_ready, sif.wgt_ready); end
    checks++; if (sif.out_valid !== 1'b1 || sif.din !== exp_din || sif.weight !== kept_wgt) begin errors++; $display("FAIL reuse_second v%b din %h weight %h exp v1 %h %h", sif.out_valid, sif.din, sif.weight, exp_din, kept_wgt); end
    step();
    checks++; if (sif.wgt_ready !== 1'b1 || sif.act_ready !== 1'b1 || sif.out_valid !== 1'b0) begin errors++; $display("FAIL reuse_release got a%b w%b v%b exp a1 w1 v0", sif.act_ready, sif.wgt_ready, sif.out_valid); end
  endtask

  task automatic test_reset_mid();
    // Run 1: reset with two beats of each stream already loaded.
    gen_small(1'b1, 1'b1);
    sif.out_ready = 1'b1;
    sif.wgt_keep  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sif.act_valid = 1'b1; sif.act_data = a_beats[i];
      sif.wgt_valid = 1'b1; sif.wgt_data = w_beats[i];
      step();
    end
    idle_small();
    #2 rst = 1'b1;
    #1;
    checks++; if (sif.din !== '0 || sif.weight !== '0) begin errors++; $display("FAIL midreset_async_vectors din %h weight %h exp 0", sif.din, sif.weight); end
    @(posedge clk);
    #1 rst = 1'b0;
    gen_small(1'b1, 1'b1);
    for (int i = 0; i < SNB; i++) begin
      sif.act_valid = 1'b1; sif.act_data = a_beats[i];
      sif.wgt_valid = 1'b1; sif.wgt_data = w_beats[i];
      step();
      if (i < SNB - 1) begin
        checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_restart_early beat %0d got %b exp 0", i, sif.out_valid); end
      end
    end
    idle_small();
    checks++; if (sif.out_valid !== 1'b1 || sif.din !== exp_din || sif.weight !== exp_wgt) begin errors++; $display("FAIL midreset_restart v%b din %h weight %h exp v1 %h %h", sif.out_valid, sif.din, sif.weight, exp_din, exp_wgt); end
    step();

    // Run 2: reset while a complete pair is being offered.
    gen_small(1'b1, 1'b1);
    sif.out_ready = 1'b0;
    for (int i = 0; i < SNB; i++) begin
      sif.act_valid = 1'b1; sif.act_data = a_beats[i];
      sif.wgt_valid = 1'b1; sif.wgt_data = w_beats[i];
      step();
    end
    idle_small();
    checks++; if (sif.out_valid !== 1'b1) begin errors++; $display("FAIL midreset_full_valid got %b exp 1", sif.out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sif.out_valid !== 1'b0 || sif.act_ready !== 1'b1 || sif.wgt_ready !== 1'b1) begin errors++; $display("FAIL midreset_async_flags got v%b a%b w%b exp v0 a1 w1", sif.out_valid, sif.act_ready, sif.wgt_ready); end
    checks++; if (sif.din !== '0 || sif.weight !== '0) begin errors++; $display("FAIL midreset_async_full din %h weight %h exp 0", sif.din, sif.weight); end
    @(posedge clk);
    #1 rst = 1'b0;
    sif.out_ready = 1'b1;
    step();
    checks++; if (sif.out_valid !== 1'b0 || sif.din !== '0) begin errors++; $display("FAIL midreset_no_hs v%b din %h exp v0 0", sif.out_valid, sif.din); end
  endtask

  // Randomized run on the default-sized instance. The reference model keeps
  // only beat counts per stream and the vectors assembled from accepted beats.
  task automatic test_random_default();
    int  act_pend = 0;
    int  wgt_pend = 0;
    int  vectors  = 0;
    int  cycles   = 0;
    bit  a_hold   = 1'b0;
    bit  w_hold   = 1'b0;
    bit  hs, a_acc, w_acc, keep;
    logic [4*BN-1:0] ea;
    logic [8*BN-1:0] ew;
    exp_act_q.delete();
    exp_wgt_q.delete();
    cur_act = '0;
    cur_wgt = '0;
    while (vectors < NVEC && cycles < 60000) begin
      checks++;
      if (bif.act_ready !== (act_pend < BNB) || bif.wgt_ready !== (wgt_pend < BNB)) begin
        errors++; $display("FAIL rand_ready cycle %0d got a%b w%b exp a%b w%b", cycles, bif.act_ready, bif.wgt_ready, act_pend < BNB, wgt_pend < BNB);
      end
      checks++;
      if (bif.out_valid !== (act_pend == BNB && wgt_pend == BNB)) begin
        errors++; $display("FAIL rand_out_valid cycle %0d got %b exp %b", cycles, bif.out_valid, act_pend == BNB && wgt_pend == BNB);
      end
      if (!a_hold && $urandom_range(0, 9) < 7) begin a_hold = 1'b1; bif.act_data = $urandom; end
      if (!w_hold && $urandom_range(0, 9) < 7) begin w_hold = 1'b1; bif.wgt_data = {$urandom, $urandom}; end
      bif.act_valid = a_hold;
      bif.wgt_valid = w_hold;
      bif.out_ready = ($urandom_range(0, 9) < 6);
      keep          = ($urandom_range(0, 9) < 3);
      bif.wgt_keep  = keep;
      hs    = (act_pend == BNB) && (wgt_pend == BNB) && bif.out_ready;
      a_acc = a_hold && (act_pend < BNB);
      w_acc = w_hold && (wgt_pend < BNB);
      if (hs) begin
        ea = exp_act_q.pop_front();
        ew = exp_wgt_q[0];
        checks++;
        if (bif.din !== ea) begin
          errors++;
          for (int b = 0; b < BNB; b++) begin
            if (bif.din[b*BAW +: BAW] !== ea[b*BAW +: BAW]) begin
              $display("FAIL rand_din vector %0d beat %0d got %h exp %h", vectors, b, bif.din[b*BAW +: BAW], ea[b*BAW +: BAW]);
              break;
            end
          end
        end
        checks++;
        if (bif.weight !== ew) begin
          errors++;
          for (int b = 0; b < BNB; b++) begin
            if (bif.weight[b*BWW +: BWW] !== ew[b*BWW +: BWW]) begin
              $display("FAIL rand_weight vector %0d beat %0d got %h exp %h", vectors, b, bif.weight[b*BWW +: BWW], ew[b*BWW +: BWW]);
              break;
            end
          end
        end
        if (!keep) begin
          void'(exp_wgt_q.pop_front());
          wgt_pend = 0;
        end
        act_pend = 0;
        vectors++;
      end
      if (a_acc) begin
        cur_act[act_pend*BAW +: BAW] = bif.act_data;
        act_pend++;
        if (act_pend == BNB) exp_act_q.push_back(cur_act);
        a_hold = 1'b0;
      end
      if (w_acc) begin
        cur_wgt[wgt_pend*BWW +: BWW] = bif.wgt_data;
        wgt_pend++;
        if (wgt_pend == BNB) exp_wgt_q.push_back(cur_wgt);
        w_hold = 1'b0;
      end
      step();
      cycles++;
    end
    bif.act_valid = 1'b0;
    bif.wgt_valid = 1'b0;
    bif.out_ready = 1'b0;
    checks++;
    if (vectors != NVEC) begin
      errors++; $display("FAIL rand_timeout vectors %0d exp %0d within %0d cycles", vectors, NVEC, cycles);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_backpressure();
    test_weight_reuse();
    test_reset_mid();
    test_random_default();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
